// File: rtl/nuc_mem_writer_pkg.sv
// Shared types and constants for the nucleotide memory writer.
// Nucleotide codes, default packing geometry and the writer FSM state type.
package nuc_pkg;

    localparam int NW_DEF   = 2;
    localparam int PACK_DEF = 4;

    localparam logic [1:0] NUC_A = 2'b00;
    localparam logic [1:0] NUC_C = 2'b01;
    localparam logic [1:0] NUC_G = 2'b10;
    localparam logic [1:0] NUC_T = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} writer_state_t;

endpackage

// File: rtl/nuc_mem_writer_if.sv
// Nucleotide stream input and memory write port of the writer.
// Stream handshake: a beat transfers on a rising clock edge where nuc_valid && nuc_ready;
// nuc_in/nuc_last are only meaningful while nuc_valid is high, and nuc_ready does not depend on nuc_valid.
interface nuc_mem_writer_if #(
    parameter int NW = 2,
    parameter int DW = 8,
    parameter int AW = 12
);
    logic [NW-1:0] nuc_in;
    logic          nuc_valid;
    logic          nuc_last;
    logic          nuc_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    modport master (
        input  nuc_in, nuc_valid, nuc_last,
        output nuc_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output nuc_in, nuc_valid, nuc_last,
        input  nuc_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/nuc_mem_writer_packer.sv
// Slot counter and pack register: places nucleotides MSB-first into a word and
// flags the accept that completes it (full word or last beat, low slots zero-padded).
module nuc_packer
    import nuc_pkg::*;
#(
    parameter int NW   = NW_DEF,
    parameter int PACK = PACK_DEF,
    parameter int DW   = NW * PACK
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          accept,
    input  logic [NW-1:0] nuc_in,
    input  logic          last,
    output logic [DW-1:0] word,
    output logic          word_done
);
    localparam int SW = (PACK > 1) ? $clog2(PACK) : 1;

    logic [SW-1:0] r_slot;
    logic [DW-1:0] r_pack;
    logic [DW-1:0] w_word;

    // Current beat merged into its slot; earlier slots come from r_pack, later ones are still zero.
    always_comb begin
        w_word = r_pack;
        for (int k = 0; k < PACK; k++) begin
            if (r_slot == SW'(k)) begin
                w_word[DW-1-NW*k -: NW] = nuc_in;
            end
        end
    end

    assign word      = w_word;
    assign word_done = accept && ((r_slot == SW'(PACK - 1)) || last);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_slot <= '0;
            r_pack <= '0;
        end else if (accept) begin
            if (word_done) begin
                r_slot <= '0;
                r_pack <= '0;
            end else begin
                r_slot <= r_slot + SW'(1);
                r_pack <= w_word;
            end
        end
    end
endmodule

// File: rtl/nuc_mem_writer.sv
// Streaming loader: packs 2-bit nucleotides into words and writes them to
// sequential addresses from 0, ending on the last beat or when memory is full.
module nuc_mem_writer
    import nuc_pkg::*;
#(
    parameter int NW   = NW_DEF,
    parameter int PACK = PACK_DEF,
    parameter int DW   = NW * PACK,
    parameter int W    = 4096,
    parameter int AW   = $clog2(W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    nuc_mem_writer_if.master  nuc_bus,
    output logic [AW:0]       word_count,
    output logic              done,
    output logic              full,
    output writer_state_t     o_dbg_state
);
    writer_state_t r_state, w_next;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_wdata;
    logic          r_we;
    logic [AW:0]   r_count;
    logic          r_done;
    logic          r_full;

    logic          w_ready;
    logic          w_accept;
    logic          w_clear;
    logic          w_at_end;
    logic [DW-1:0] w_word;
    logic          w_word_done;

    assign w_ready  = (r_state == LOAD);
    assign w_accept = nuc_bus.nuc_valid && w_ready;
    assign w_clear  = start && (r_state != LOAD);
    assign w_at_end = (r_addr == AW'(W - 1));

    nuc_packer #(.NW(NW), .PACK(PACK), .DW(DW)) u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_clear),
        .accept    (w_accept),
        .nuc_in    (nuc_bus.nuc_in),
        .last      (nuc_bus.nuc_last),
        .word      (w_word),
        .word_done (w_word_done)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    if (w_word_done && (nuc_bus.nuc_last || w_at_end)) w_next = DONE;
            DONE:    if (start) w_next = LOAD;
            default: w_next = IDLE;
        endcase
    end

    // Reset wins over a write completing on the same edge, so no stray strobe escapes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_mem_addr <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_we    <= w_word_done;
            if (w_clear) begin
                r_addr  <= '0;
                r_count <= '0;
                r_done  <= 1'b0;
                r_full  <= 1'b0;
            end else if (w_word_done) begin
                r_mem_addr <= r_addr;
                r_wdata    <= w_word;
                r_count    <= r_count + (AW+1)'(1);
                if (!w_at_end) begin
                    r_addr <= r_addr + AW'(1);
                end
                if (nuc_bus.nuc_last || w_at_end) begin
                    r_done <= 1'b1;
                    r_full <= !nuc_bus.nuc_last;
                end
            end
        end
    end

    assign nuc_bus.nuc_ready = w_ready;
    assign nuc_bus.mem_we    = r_we;
    assign nuc_bus.mem_addr  = r_mem_addr;
    assign nuc_bus.mem_wdata = r_wdata;
    assign word_count        = r_count;
    assign done              = r_done;
    assign full              = r_full;
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_nuc_mem_writer.sv
// Bench for nuc_mem_writer: directed scenarios plus random loads, checked every
// cycle against a queue-based model of the load/pack/write rules.
module tb_nuc_mem_writer;
    import nuc_pkg::*;

    localparam int NW   = 2;
    localparam int PACK = 4;
    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int AW   = 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clock = ~clock;

    logic [AW:0]   word_count;
    logic          done;
    logic          full;
    writer_state_t dbg_state;

    nuc_mem_writer_if #(.NW(NW), .DW(DW), .AW(AW)) bus ();

    nuc_mem_writer #(.NW(NW), .PACK(PACK), .DW(DW), .W(W), .AW(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .nuc_bus     (bus),
        .word_count  (word_count),
        .done        (done),
        .full        (full),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    writer_state_t     m_state = IDLE;
    logic [1:0]        m_nucs[$];
    int                m_addr, m_count, m_last_addr, m_last_data;
    bit                m_done, m_full;
    logic [AW+DW-1:0]  exp_q[$];
    logic [AW+DW-1:0]  e;
    int                log_addr[$];
    int                log_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a load collects accepted nucleotides; every PACK of them (or the last)
    // becomes one word written at the next address, padded with A (00) on the right.
    always @(posedge clock) begin
        int data;
        chk_en = 1;
        if (reset) begin
            m_state = IDLE;
            m_nucs.delete();
            m_addr = 0; m_count = 0; m_done = 0; m_full = 0;
            m_last_addr = 0; m_last_data = 0;
            exp_q.delete();
        end else if (m_state != LOAD) begin
            if (start) begin
                m_state = LOAD;
                m_nucs.delete();
                m_addr = 0; m_count = 0; m_done = 0; m_full = 0;
            end
        end else if (bus.nuc_valid) begin
            m_nucs.push_back(bus.nuc_in);
            if (m_nucs.size() == PACK || bus.nuc_last) begin
                data = 0;
                foreach (m_nucs[i]) data += int'(m_nucs[i]) << (DW - NW * (i + 1));
                exp_q.push_back({AW'(m_addr), DW'(data)});
                m_last_addr = m_addr;
                m_last_data = data;
                m_count++;
                m_nucs.delete();
                if (bus.nuc_last) begin
                    m_state = DONE; m_done = 1; m_full = 0;
                end else if (m_addr == W - 1) begin
                    m_state = DONE; m_done = 1; m_full = 1;
                end
                m_addr++;
            end
        end
    end

    // Compare process: outputs are registered, so sample on the falling edge.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("nuc_ready", 32'(bus.nuc_ready), 32'(m_state == LOAD));
            chk("state", 32'(dbg_state), 32'(m_state));
            chk("mem_we", 32'(bus.mem_we), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(e[AW+DW-1:DW]));
                chk("wr_data", 32'(bus.mem_wdata), 32'(e[DW-1:0]));
            end
            if (bus.mem_we === 1'b1) begin
                log_addr.push_back(int'(bus.mem_addr));
                log_data.push_back(int'(bus.mem_wdata));
            end
            chk("mem_addr", 32'(bus.mem_addr), 32'(m_last_addr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_last_data));
            chk("done", 32'(done), 32'(m_done));
            chk("full", 32'(full), 32'(m_full));
            chk("word_count", 32'(word_count), 32'(m_count));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit s, input bit v, input logic [1:0] n, input bit l);
        @(negedge clock);
        start         = s;
        bus.nuc_valid = v;
        bus.nuc_in    = n;
        bus.nuc_last  = l;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 2'b00, 0);
    endtask

    // Sends len nucleotides from seq (first nucleotide in the highest bits), last on the final one.
    task automatic send_seq(input logic [23:0] seq, input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps) cyc(0, 0, 2'b00, 0);
            cyc(0, 1, seq[2*(len-1-i) +: 2], i == len - 1);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic chk_log(input string name, input int idx, input int a, input int d);
        if (idx < log_addr.size()) begin
            chk({name, "_addr"}, 32'(log_addr[idx]), 32'(a));
            chk({name, "_data"}, 32'(log_data[idx]), 32'(d));
        end else begin
            chk({name, "_present"}, 32'(log_addr.size()), 32'(idx + 1));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.nuc_valid = 1'b0;
        bus.nuc_last  = 1'b0;
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit   did_reset;
        int   len;
        bus.nuc_in = 2'b00; bus.nuc_valid = 1'b0; bus.nuc_last = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(1);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_ready", 32'(bus.nuc_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);

        // Single full word A,C,G,T
        clear_log();
        cyc(1, 0, 2'b00, 0);
        send_seq(24'h1B, 4, 0);
        idle(2);
        chk("t1_writes", 32'(log_addr.size()), 32'd1);
        chk_log("t1_w0", 0, 0, 8'h1B);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_full", 32'(full), 32'd0);
        chk("t1_count", 32'(word_count), 32'd1);

        // Partial word G,G,T,A,C,C and the same with gappy valid
        for (int g = 0; g < 2; g++) begin
            clear_log();
            cyc(1, 0, 2'b00, 0);
            send_seq(24'hAC5, 6, g[0]);
            idle(2);
            chk("t2_writes", 32'(log_addr.size()), 32'd2);
            chk_log("t2_w0", 0, 0, 8'hAC);
            chk_log("t2_w1", 1, 1, 8'h50);
            chk("t2_count", 32'(word_count), 32'd2);
            chk("t2_done", 32'(done), 32'd1);
        end

        // Fill all W words with T, extra beats ignored
        clear_log();
        cyc(1, 0, 2'b00, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, NUC_T, 0);
        idle(2);
        chk("t4_writes", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_log("t4_w", i, i, 8'hFF);
        chk("t4_ready", 32'(bus.nuc_ready), 32'd0);
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_count", 32'(word_count), 32'd4);

        // Last beat on the final address: last wins, full stays low
        cyc(1, 0, 2'b00, 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, NUC_G, i == 15);
        idle(2);
        chk("lastwins_full", 32'(full), 32'd0);
        chk("lastwins_done", 32'(done), 32'd1);

        // Reset mid-load, then a clean load of A,A,A,A
        clear_log();
        cyc(1, 0, 2'b00, 0);
        cyc(0, 1, NUC_C, 0); cyc(0, 1, NUC_G, 0); cyc(0, 1, NUC_T, 0);
        pulse_reset();
        idle(1);
        chk("t5_writes", 32'(log_addr.size()), 32'd0);
        chk("t5_ready", 32'(bus.nuc_ready), 32'd0);
        chk("t5_count", 32'(word_count), 32'd0);
        chk("t5_state", 32'(dbg_state), 32'(IDLE));
        cyc(1, 0, 2'b00, 0);
        send_seq(24'h00, 4, 0);
        idle(2);
        chk_log("t5_w0", 0, 0, 8'h00);

        // Reset on the edge that completes a word suppresses the write
        clear_log();
        cyc(1, 0, 2'b00, 0);
        cyc(0, 1, NUC_C, 0); cyc(0, 1, NUC_C, 0); cyc(0, 1, NUC_C, 0);
        cyc(0, 1, NUC_C, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; bus.nuc_valid = 1'b0; bus.nuc_last = 1'b0;
        idle(2);
        chk("rstwr_writes", 32'(log_addr.size()), 32'd0);

        // Start during LOAD ignored; start in DONE begins a fresh load
        clear_log();
        cyc(1, 0, 2'b00, 0);
        cyc(0, 1, NUC_A, 0); cyc(0, 1, NUC_C, 0);
        cyc(1, 1, NUC_G, 0); cyc(0, 1, NUC_T, 1);
        idle(2);
        chk("t6_writes", 32'(log_addr.size()), 32'd1);
        chk_log("t6_w0", 0, 0, 8'h1B);
        cyc(1, 0, 2'b00, 0);
        cyc(0, 0, 2'b00, 0);
        chk("t6_done_drop", 32'(done), 32'd0);
        chk("t6_count_clr", 32'(word_count), 32'd0);
        chk("t6_ready", 32'(bus.nuc_ready), 32'd1);
        clear_log();
        send_seq(24'h1B, 4, 0);
        idle(2);
        chk_log("t6_w1", 0, 0, 8'h1B);

        // Random loads
        for (int l = 0; l < 60; l++) begin
            did_reset = 0;
            cyc(1, 0, 2'b00, 0);
            len = $urandom_range(1, 20);
            for (int i = 0; i < len && !did_reset; i++) begin
                for (int g = $urandom_range(0, 3); g > 0; g--)
                    cyc($urandom_range(0, 9) == 0, 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1));
                if ($urandom_range(0, 39) == 0) begin
                    pulse_reset();
                    did_reset = 1;
                end else begin
                    cyc($urandom_range(0, 9) == 0, 1, 2'($urandom_range(0, 3)), i == len - 1);
                end
            end
            idle($urandom_range(1, 3));
        end

        idle(3);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
